inst_sram_resp: RTL and testbench

INST_SRAM_RESP -- requirements
Module: inst_sram_resp

---
 rtl/inst_sram_if.sv | 26 ++
 rtl/inst_sram_resp.sv | 103 ++++++++++
 tb/tb_inst_sram_resp.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_sram_if.sv
// Fetch-side request/response bus plus loader write port for the instruction SRAM responder.
interface inst_sram_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;
   logic [31:0] rsp_count;

   // Fetcher/loader side: drives requests and writes, consumes responses.
   modport master (
      output req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
      input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_count
   );

   // Responder side.
   modport slave (
      input  req_valid, req_addr, rsp_ready, wr_en, wr_addr, wr_data,
      output req_ready, rsp_valid, rsp_data, rsp_err, rsp_count
   );
endinterface

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: one outstanding fetch, fixed latency, registered response with
// access-fault detection, plus a loader write port usable in any state.
module inst_sram_resp #(
   parameter int unsigned DEPTH   = 4096,
   parameter int unsigned LATENCY = 2,
   parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000
) (
   input  logic       clk,
   input  logic       reset,
   inst_sram_if.slave bus
);

   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd4;
   localparam logic [3:0]  LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic [31:0] rsp_count_q, rsp_count_d;

   logic [31:0] mem [DEPTH];

   function automatic logic addr_fault(logic [63:0] a);
      return (a[1:0] != 2'b00) || (a < BASE) || (a >= LIMIT);
   endfunction

   function automatic logic [AW-1:0] word_idx(logic [63:0] a);
      return AW'((a - BASE) >> 2);
   endfunction

   // Loader writes; no reset so preloaded code survives a core reset.
   always_ff @(posedge clk) begin
      if (bus.wr_en && !addr_fault(bus.wr_addr)) begin
         mem[word_idx(bus.wr_addr)] <= bus.wr_data;
      end
   end

   // Next-state: accept in idle, count down the latency, hold the response until taken.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_count_d = rsp_count_q;
      unique case (state_q)
         StIdle: begin
            if (bus.req_valid) begin
               state_d = StWait;
               cnt_d   = LAT;
               addr_d  = bus.req_addr;
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // Array read sees pre-edge contents, so a same-edge write returns the old word.
               state_d    = StResp;
               rsp_err_d  = addr_fault(addr_q);
               rsp_data_d = rsp_err_d ? 32'h0 : mem[word_idx(addr_q)];
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d     = StIdle;
               rsp_count_d = rsp_count_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and response registers; reset drops any pending fetch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         addr_q      <= 64'h0;
         rsp_data_q  <= 32'h0;
         rsp_err_q   <= 1'b0;
         rsp_count_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_count_q <= rsp_count_d;
      end
   end

   assign bus.req_ready = (state_q == StIdle);
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_count = rsp_count_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Bench for inst_sram_resp: directed scenarios with literal expectations plus a randomized
// phase, all outputs compared every cycle against a transaction-level model.
module tb_inst_sram_resp;

   localparam int unsigned DEPTH = 256;
   localparam int unsigned L     = 2;
   localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
   localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'd4;

   logic clk;
   logic reset;
   inst_sram_if bus ();

   inst_sram_resp #(
      .DEPTH   (DEPTH),
      .LATENCY (L),
      .BASE    (BASE)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned total  = 0;
   int unsigned passed = 0;
   bit          run_cmp = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   // ---------------- reference model ----------------
   logic [31:0] m_mem [DEPTH];
   bit          m_busy  = 0;
   int          m_age   = 0;
   logic [63:0] m_addr  = '0;
   logic [31:0] m_data  = '0;
   logic        m_err   = 0;
   logic [31:0] m_count = '0;

   function automatic bit addr_ok(logic [63:0] a);
      return (a[1:0] == 2'b00) && (a >= BASE) && (a < LIMIT);
   endfunction

   function automatic int widx(logic [63:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   function automatic logic [31:0] pat(int i);
      logic [15:0] h;
      h = 16'(i);
      return (i == 0) ? 32'h0000_0413 : {h ^ 16'h5A00, ~h};
   endfunction

   always @(posedge reset) begin
      m_busy  = 0;
      m_age   = 0;
      m_count = '0;
   end

   // A fetch is "busy" from its accept until its handshake; the response is due L edges in.
   always @(posedge clk) begin
      if (reset) begin
         m_busy  = 0;
         m_age   = 0;
         m_count = '0;
      end else if (!m_busy) begin
         if (bus.req_valid) begin
            m_busy = 1;
            m_age  = 0;
            m_addr = bus.req_addr;
         end
      end else if (m_age == int'(L)) begin
         if (bus.rsp_ready) begin
            m_busy  = 0;
            m_count = m_count + 32'd1;
         end
      end else begin
         m_age++;
         if (m_age == int'(L)) begin
            m_err  = !addr_ok(m_addr);
            m_data = m_err ? 32'h0 : m_mem[widx(m_addr)];
         end
      end
      // Memory update after the snapshot so a same-edge write is not seen.
      if (bus.wr_en && addr_ok(bus.wr_addr)) m_mem[widx(bus.wr_addr)] = bus.wr_data;
   end

   // Per-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (run_cmp && !reset) begin
         chk("req_ready", bus.req_ready, !m_busy);
         chk("rsp_valid", bus.rsp_valid, m_busy && (m_age == int'(L)));
         chk("rsp_count", bus.rsp_count, m_count);
         if (m_busy && (m_age == int'(L))) begin
            chk("rsp_data", bus.rsp_data, m_data);
            chk("rsp_err", bus.rsp_err, m_err);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [63:0] a, input int stall,
                        output logic [31:0] d, output logic e);
      int n;
      bus.req_valid = 1'b1;
      bus.req_addr  = a;
      n = 0;
      while (!bus.req_ready && n < 40) begin
         step();
         n++;
      end
      step();
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         step();
         n++;
      end
      chk("fetch_latency", 64'(n), 64'(L));
      d = bus.rsp_data;
      e = bus.rsp_err;
      repeat (stall) step();
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        e;
      int          acc [$];
      logic [63:0] bad [3];

      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.rsp_ready = 1'b0;
      bus.wr_en     = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      reset         = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_req_ready", bus.req_ready, 1);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_data", bus.rsp_data, 0);
      chk("reset_rsp_err", bus.rsp_err, 0);
      chk("reset_rsp_count", bus.rsp_count, 0);
      reset   = 1'b0;
      run_cmp = 1;

      // Preload every word, then two illegal writes that must be dropped.
      for (int i = 0; i < int'(DEPTH); i++) begin
         bus.wr_en   = 1'b1;
         bus.wr_addr = BASE + 64'(4 * i);
         bus.wr_data = pat(i);
         step();
      end
      bus.wr_addr = BASE + 64'd1;
      bus.wr_data = 32'hBAD0_0001;
      step();
      bus.wr_addr = LIMIT;
      bus.wr_data = 32'hBAD0_0002;
      step();
      bus.wr_en = 1'b0;

      // Basic fetch with exact latency.
      bus.req_valid = 1'b1;
      bus.req_addr  = BASE;
      step();
      bus.req_valid = 1'b0;
      chk("basic_busy", bus.req_ready, 0);
      chk("basic_valid_e0", bus.rsp_valid, 0);
      step();
      chk("basic_valid_e1", bus.rsp_valid, 0);
      step();
      chk("basic_valid_e2", bus.rsp_valid, 1);
      chk("basic_data", bus.rsp_data, 32'h0000_0413);
      chk("basic_err", bus.rsp_err, 0);
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("basic_count", bus.rsp_count, 1);
      chk("basic_idle", bus.req_ready, 1);

      // Faulting addresses.
      bad[0] = BASE + 64'd2;
      bad[1] = 64'h0000_0000_7FFF_FFFC;
      bad[2] = LIMIT;
      for (int i = 0; i < 3; i++) begin
         fetch(bad[i], 0, d, e);
         chk("fault_err", 64'(e), 1);
         chk("fault_data", d, 0);
      end

      // Stall in the response state with a competing request pending.
      bus.req_valid = 1'b1;
      bus.req_addr  = BASE + 64'd12;
      step();
      bus.req_addr  = BASE + 64'd16;
      step();
      step();
      chk("stall_valid0", bus.rsp_valid, 1);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("stall_valid", bus.rsp_valid, 1);
         chk("stall_data", bus.rsp_data, pat(3));
         chk("stall_ready", bus.req_ready, 0);
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      chk("stall_not_accepted", bus.req_ready, 1);

      // Write the fetched word on the edge that enters the response state.
      bus.req_valid = 1'b1;
      bus.req_addr  = BASE + 64'd20;
      step();
      bus.req_valid = 1'b0;
      step();
      bus.wr_en   = 1'b1;
      bus.wr_addr = BASE + 64'd20;
      bus.wr_data = 32'hDEAD_BEEF;
      step();
      bus.wr_en = 1'b0;
      chk("wr_race_valid", bus.rsp_valid, 1);
      chk("wr_race_old", bus.rsp_data, pat(5));
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      fetch(BASE + 64'd20, 0, d, e);
      chk("wr_race_new", d, 32'hDEAD_BEEF);

      // Reset during the wait drops the fetch but keeps memory.
      bus.req_valid = 1'b1;
      bus.req_addr  = BASE + 64'd8;
      step();
      bus.req_valid = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("rst_wait_ready", bus.req_ready, 1);
      chk("rst_wait_valid", bus.rsp_valid, 0);
      chk("rst_wait_count", bus.rsp_count, 0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rst_no_rsp", bus.rsp_valid, 0);
      end
      fetch(BASE, 0, d, e);
      chk("rst_mem_kept", d, 32'h0000_0413);

      // Back-to-back fetches: L wait cycles, one response cycle taken at once, one idle cycle.
      bus.req_valid = 1'b1;
      bus.req_addr  = BASE + 64'd8;
      bus.rsp_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (bus.req_ready) acc.push_back(c);
         step();
      end
      bus.req_valid = 1'b0;
      repeat (L + 2) step();
      bus.rsp_ready = 1'b0;
      chk("b2b_accepts", 64'(acc.size()), 5);
      for (int i = 1; i < acc.size(); i++) chk("b2b_spacing", 64'(acc[i] - acc[i-1]), 64'(L + 2));

      // Counter wrap.
      force dut.rsp_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.rsp_count_q;
      m_count = 32'hFFFF_FFFF;
      fetch(BASE + 64'd4, 0, d, e);
      chk("wrap_count", bus.rsp_count, 0);

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         int k;
         k = int'($urandom_range(0, 9));
         bus.req_valid = ($urandom_range(0, 1) == 1);
         if (k <= 6)      bus.req_addr = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
         else if (k == 7) bus.req_addr = BASE + 64'(4 * $urandom_range(0, DEPTH - 1) + 1);
         else if (k == 8) bus.req_addr = BASE - 64'(4 * $urandom_range(1, 8));
         else             bus.req_addr = LIMIT + 64'(4 * $urandom_range(0, 8));
         bus.rsp_ready = ($urandom_range(0, 9) < 7);
         bus.wr_en     = ($urandom_range(0, 3) == 0);
         bus.wr_addr   = ($urandom_range(0, 4) == 0) ? LIMIT + 64'($urandom_range(0, 3))
                                                     : BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
         bus.wr_data   = $urandom;
         reset         = ($urandom_range(0, 199) == 0);
         step();
      end
      reset         = 1'b0;
      bus.req_valid = 1'b0;
      bus.wr_en     = 1'b0;
      bus.rsp_ready = 1'b1;
      repeat (L + 3) step();
      run_cmp = 0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
